// File: rtl/regfile_dump.sv
// regfile_dump: walks every register file entry and streams a header byte plus each word LSB-first over a valid/ready byte port
module regfile_dump #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] asel,
    input  logic [DWIDTH-1:0] adata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);
    localparam int NB = DWIDTH / 8;
    typedef enum logic [1:0] {IDLE, HDR, LOAD, SEND} state_t;
    state_t            state, nxt;
    logic [AWIDTH-1:0] addr;
    logic [2:0]        bidx;
    logic [DWIDTH-1:0] word;
    logic              hs, last_byte, last_reg;
    assign hs        = tx_valid && tx_ready;
    assign last_byte = bidx == 3'(NB - 1);
    assign last_reg  = &addr;
    assign asel      = addr;
    assign busy      = state != IDLE;
    assign tx_valid  = state == HDR || state == SEND;
    assign tx_data   = state == HDR ? 8'hA5 : state == SEND ? word[7:0] : 8'h00;
    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : nxt;
    end
    // next-state: header, then one LOAD and NB SEND beats per register
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = start ? HDR : IDLE;
            HDR:  nxt = hs ? LOAD : HDR;
            LOAD: nxt = SEND;
            SEND: nxt = hs && last_byte ? (last_reg ? IDLE : LOAD) : SEND;
        endcase
    end
    // address sequencing, word snapshot/shift and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
            bidx <= '0;
            word <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) addr <= '0;
                LOAD: begin
                    word <= adata;
                    bidx <= '0;
                end
                SEND: if (hs) begin
                    word <= word >> 8;
                    bidx <= bidx + 3'd1;
                    if (last_byte) begin
                        if (last_reg) begin
                            done <= 1'b1;
                            addr <= '0;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed checks of header, byte order, stalls, snapshot timing, restart and abort
module tb_regfile_dump;
    logic        clk = 0, reset = 1, start = 0, tx_ready = 0;
    logic        busy, done, tx_valid;
    logic [3:0]  asel;
    logic [15:0] adata;
    logic [7:0]  tx_data;
    logic [15:0] rf [16];
    logic        start2 = 0, busy2, done2, tx_valid2;
    logic [1:0]  asel2;
    logic [31:0] adata2;
    logic [7:0]  tx_data2;
    logic [31:0] rf2 [4];
    int          tests = 0, fails = 0;
    int          nbusy, ndone;
    logic [7:0]  got[$], expq[$];

    always #5 clk = ~clk;
    assign adata  = rf[asel];
    assign adata2 = rf2[asel2];

    regfile_dump dut (.clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .asel(asel), .adata(adata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready));
    regfile_dump #(.AWIDTH(2), .DWIDTH(32)) dut2 (.clk(clk), .reset(reset), .start(start2),
        .busy(busy2), .done(done2), .asel(asel2), .adata(adata2), .tx_data(tx_data2),
        .tx_valid(tx_valid2), .tx_ready(1'b1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp();
        expq.delete();
        expq.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin
            expq.push_back(rf[i][7:0]);
            expq.push_back(rf[i][15:8]);
        end
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, got.size(), expq.size());
        for (int k = 0; k < got.size() && k < expq.size(); k++) chk($sformatf("%s_b%0d", tag, k), got[k], expq[k]);
    endtask

    // runs from the HDR cycle up to and including the done cycle
    task automatic collect(input bit rnd, input bit wr, input bit spam);
        logic pv, wrote;
        logic [7:0] pd;
        got.delete();
        nbusy = 0; ndone = 0; pv = 0; pd = 0; wrote = 0;
        for (int c = 0; c < 2000; c++) begin
            if (pv) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, pd);
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                chk("done_busy", busy, 0);
                break;
            end
            if (wr && !wrote && tx_valid && asel == 4'd3) begin
                rf[3] = 16'hBEEF;
                rf[5] = 16'h1234;
                wrote = 1;
            end
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = spam && busy;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            pv = tx_valid && !tx_ready;
            pd = tx_data;
            tick();
        end
        start = 0;
        chk("done_seen", ndone, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'h1100 + 16'(i);
        for (int i = 0; i < 4; i++) rf2[i] = 32'hA0B0C0D0 + 32'(i);
        tick();
        tick();
        chk("rst_asel", asel, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 0;
        tick();
        chk("idle_busy", busy, 0);

        build_exp();
        start = 1; tick(); start = 0;
        chk("hdr_valid", tx_valid, 1);
        chk("hdr_data", tx_data, 8'hA5);
        collect(0, 0, 0);
        cmp_stream("basic");
        chk("basic_busy_cycles", nbusy, 49);
        tick();
        chk("done_one_cycle", done, 0);

        start = 1; tick(); start = 0;
        collect(1, 0, 0);
        cmp_stream("stall");

        build_exp();
        expq[11] = 8'h34;
        expq[12] = 8'h12;
        start = 1; tick(); start = 0;
        collect(0, 1, 0);
        cmp_stream("snap");
        for (int i = 0; i < 16; i++) rf[i] = 16'h1100 + 16'(i);

        build_exp();
        start = 1; tick(); start = 0;
        collect(1, 0, 1);
        cmp_stream("spam");
        start = 1; tick(); start = 0;
        chk("restart_valid", tx_valid, 1);
        chk("restart_data", tx_data, 8'hA5);
        collect(0, 0, 0);
        cmp_stream("restart");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_queue_busy", busy, 0);
        end

        start = 1; tick(); start = 0;
        tx_ready = 1;
        for (int c = 0; c < 200 && !(tx_valid && asel == 4'd7); c++) tick();
        chk("reach_addr7", {tx_valid, asel}, {1'b1, 4'd7});
        reset = 1; tick(); reset = 0;
        chk("abort_valid", tx_valid, 0);
        chk("abort_asel", asel, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", done, 0);
        end
        start = 1; tick(); start = 0;
        collect(1, 0, 0);
        cmp_stream("after_abort");

        got.delete();
        expq.delete();
        expq.push_back(8'hA5);
        for (int i = 0; i < 4; i++) for (int b = 0; b < 4; b++) expq.push_back(8'(rf2[i] >> (8 * b)));
        start2 = 1; tick(); start2 = 0;
        ndone = 0;
        for (int c = 0; c < 200 && !done2; c++) begin
            if (tx_valid2) got.push_back(tx_data2);
            tick();
        end
        chk("w32_done", done2, 1);
        cmp_stream("w32");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug readout engine for the CPU register file. On a start request it walks every register through one read port and streams the contents as bytes over a valid/ready byte interface, such as a debug UART transmitter or trace FIFO. It is the read-side counterpart to the register file's write path. The register file owns the storage and the read port (address in, data out combinationally in the same cycle); this block owns the address sequencing and serialization.

## Interface
Parameters:
- AWIDTH, 4: register address width; 2^AWIDTH registers are dumped.
- DWIDTH, 16: register width. Must be a multiple of 8 in the range 8..32. NB = DWIDTH/8 bytes per register.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  dump request; sampled only in IDLE.
- busy  out  1  high in HDR, LOAD and SEND.
- done  out  1  one-cycle pulse after the final byte handshake.
- asel  out  AWIDTH  register file read address; equals the internal addr register.
- adata  in  DWIDTH  register file read data, combinational from asel.
- tx_data  out  8  byte to send.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte; a handshake occurs when tx_valid and tx_ready are both high on a clock edge.

## Operation
- States:
  - IDLE: wait for a request.
  - HDR: present the header byte 0xA5.
  - LOAD: snapshot adata into the word register.
  - SEND: present word bytes, least-significant first.
- Reset: state=IDLE, addr=0, bidx=0, word=0, done=0. All outputs read 0 (asel=0, tx_valid=0, tx_data=0x00, busy=0).
- IDLE:
  - start=1: addr<=0, go to HDR.
  - start=0: remain in IDLE.
- HDR: tx_valid=1, tx_data=0xA5. On handshake, go to LOAD.
- LOAD: word<=adata at the current asel, bidx<=0, go to SEND. tx_valid=0.
- SEND: tx_valid=1, tx_data=word[7:0]. On handshake: word<=word>>8 and bidx<=bidx+1. When bidx==NB-1:
  - addr==2^AWIDTH-1: go to IDLE, done<=1, addr<=0.
  - otherwise: addr<=addr+1 (no overflow possible), go to LOAD.
- tx_data=0x00 in IDLE and LOAD.
- While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold unchanged (no retraction).
- Per-register consistency: the word is captured in LOAD. Register file writes to that register during SEND are not reflected; writes to later registers before their LOAD are reflected.
- start while busy is ignored; no queuing.
- reset mid-dump aborts immediately. The stream is truncated, done is not pulsed, and the sink sees tx_valid=0 from the cycle after the reset edge.
- Byte count per dump: 1 + 2^AWIDTH*NB.

## Timing
- start sampled high in IDLE at edge 0 gives HDR with tx_valid=1 in cycle 1.
- Minimum per-register cost is NB+1 cycles (1 LOAD + NB SEND), with tx_ready held high.
- Minimum dump duration with tx_ready held high: 1 + 2^AWIDTH*(NB+1) cycles of busy. Defaults: 49 cycles.
- done is high for exactly one cycle, the cycle after the final handshake, with busy=0. A start sampled in that cycle is accepted.
- asel changes only at the LOAD entry edge or in IDLE. Required adata path: asel register through regfile read mux to word register, in one cycle.
- All outputs are derived from registered state only; no input-to-output combinational path.

## Test plan
- Reset, then preload R[i]=16'h1100+i with AWIDTH=4, DWIDTH=16, tx_ready=1, pulse start -> 33 bytes: A5 00 11 01 11 … 0F 11. busy high for 49 cycles, then a one-cycle done.
- Same as above with tx_ready toggling pseudo-randomly -> identical byte sequence; tx_data stable whenever valid&&!ready; done count = 1.
- Write R[3]=16'hBEEF during the cycle after LOAD of R[3], then R[5]=16'h1234 before LOAD of R[5] -> bytes for R[3] are the old value; bytes for R[5] are 34 12.
- Pulse start repeatedly during a dump -> exactly one 33-byte stream. A start in the done cycle begins a second stream whose first byte is A5 in the next cycle.
- Assert reset while in SEND at addr=7 -> tx_valid=0 and asel=0 next cycle, no done pulse. A subsequent start yields a complete 33-byte stream.
- DWIDTH=32, AWIDTH=2, R[i]=32'hA0B0C0D0+i -> 17 bytes: A5, then D0 C0 B0 A0, D1 C0 B0 A0, … in little-endian order.
